// File: rtl/hwpe_stream_upsizer.sv
// hwpe_stream_upsizer
//   Packs FACTOR consecutive DATA_WIDTH beats into one FACTOR*DATA_WIDTH beat.
//   Beat 0 lands in the least-significant lane. A flush_i pulse emits the partially
//   filled word with the unfilled lanes (data and strobe) forced to zero.
//
//   Handshake rule for both streams: a beat transfers on a rising clk_i edge where
//   valid and ready are both high; once valid is raised the source holds data/strb
//   stable until that edge. pop_valid/pop_data/pop_strb come straight from registers.
//
//   Optional feature: define HWPE_STREAM_UPSIZER_STATS_EN to add words_o, a wrapping
//   32-bit count of wide words handed off (pop handshakes, flushed words included).
module hwpe_stream_upsizer #(
    parameter int DATA_WIDTH = 32,
    parameter int FACTOR     = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           flush_i,
    input  logic                           push_valid,
    output logic                           push_ready,
    input  logic [DATA_WIDTH-1:0]          push_data,
    input  logic [DATA_WIDTH/8-1:0]        push_strb,
    output logic                           pop_valid,
    input  logic                           pop_ready,
    output logic [FACTOR*DATA_WIDTH-1:0]   pop_data,
    output logic [FACTOR*DATA_WIDTH/8-1:0] pop_strb,
    output logic [$clog2(FACTOR):0]        lanes_o,
    output logic                           empty_o
`ifdef HWPE_STREAM_UPSIZER_STATS_EN
    ,
    output logic [31:0]                    words_o
`endif
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int LW = $clog2(FACTOR) + 1;
    localparam logic [LW-1:0] LAST_IDX = LW'(FACTOR - 1);

    // accumulator lanes, lane index and output register
    logic [FACTOR-1:0][DATA_WIDTH-1:0] acc_data_q;
    logic [FACTOR-1:0][SW-1:0]         acc_strb_q;
    logic [LW-1:0]                     idx_q;
    logic [FACTOR*DATA_WIDTH-1:0]      out_data_q;
    logic [FACTOR*SW-1:0]              out_strb_q;
    logic                              out_valid_q;
    logic                              flush_pend_q;

    // combinational helpers
    logic                              slot_free;
    logic                              push_hs;
    logic                              pop_hs;
    logic                              complete;
    logic                              flush_req;
    logic [LW-1:0]                     eff_cnt;
    logic                              do_flush;
    logic                              load_word;
    logic                              pend_nxt;
    logic [FACTOR-1:0][DATA_WIDTH-1:0] acc_data_nxt;
    logic [FACTOR-1:0][SW-1:0]         acc_strb_nxt;
    logic [FACTOR-1:0][DATA_WIDTH-1:0] word_data;
    logic [FACTOR-1:0][SW-1:0]         word_strb;

    // The output slot can take a new word when empty or when it is popped this cycle.
    assign slot_free  = ~out_valid_q | pop_ready;
    // The last lane may only be accepted when the completed word has somewhere to go;
    // a pending flush freezes the accumulator until the partial word is handed off.
    assign push_ready = ((idx_q != LAST_IDX) | slot_free) & ~flush_pend_q;
    assign push_hs    = push_valid & push_ready;
    assign pop_hs     = out_valid_q & pop_ready;
    assign complete   = push_hs & (idx_q == LAST_IDX);
    assign flush_req  = flush_i | flush_pend_q;
    // A completing push empties the accumulator, so a flush alongside it sees zero lanes.
    assign eff_cnt    = complete ? '0 : (idx_q + LW'(push_hs));
    assign do_flush   = flush_req & (eff_cnt != '0) & slot_free;
    assign pend_nxt   = flush_req & (eff_cnt != '0) & ~slot_free;
    assign load_word  = complete | do_flush;

    // Merge the accepted beat into the lanes and build the (possibly partial) word.
    always_comb begin
        acc_data_nxt = acc_data_q;
        acc_strb_nxt = acc_strb_q;
        word_data    = '0;
        word_strb    = '0;
        for (int l = 0; l < FACTOR; l++) begin
            if (push_hs && (int'(idx_q) == l)) begin
                acc_data_nxt[l] = push_data;
                acc_strb_nxt[l] = push_strb;
            end
            if (complete || (l < int'(eff_cnt))) begin
                word_data[l] = acc_data_nxt[l];
                word_strb[l] = acc_strb_nxt[l];
            end
        end
    end

    // State registers; clear_i overrides every other event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_data_q   <= '0;
            acc_strb_q   <= '0;
            idx_q        <= '0;
            out_data_q   <= '0;
            out_strb_q   <= '0;
            out_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
        end else if (clear_i) begin
            acc_data_q   <= '0;
            acc_strb_q   <= '0;
            idx_q        <= '0;
            out_data_q   <= '0;
            out_strb_q   <= '0;
            out_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            if (push_hs) begin
                acc_data_q <= acc_data_nxt;
                acc_strb_q <= acc_strb_nxt;
            end
            if (load_word) begin
                acc_strb_q  <= '0;
                out_data_q  <= word_data;
                out_strb_q  <= word_strb;
                out_valid_q <= 1'b1;
                idx_q       <= '0;
            end else begin
                if (pop_hs) begin
                    out_valid_q <= 1'b0;
                end
                if (push_hs) begin
                    idx_q <= idx_q + LW'(1);
                end
            end
            flush_pend_q <= pend_nxt;
        end
    end

    assign pop_valid = out_valid_q;
    assign pop_data  = out_data_q;
    assign pop_strb  = out_strb_q;
    assign lanes_o   = idx_q;
    assign empty_o   = (idx_q == '0) & ~out_valid_q & ~flush_pend_q;

`ifdef HWPE_STREAM_UPSIZER_STATS_EN
    logic [31:0] words_q;

    // Count wide words handed off downstream; wraps naturally at 2^32.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            words_q <= '0;
        end else if (clear_i) begin
            words_q <= '0;
        end else if (pop_hs) begin
            words_q <= words_q + 32'd1;
        end
    end

    assign words_o = words_q;
`endif

endmodule

// File: tb/tb_hwpe_stream_upsizer.sv
// tb_hwpe_stream_upsizer
//   Directed scenarios followed by random traffic. A lane-list model turns every
//   observed push/flush into expected wide words; every pop is compared against it.
module tb_hwpe_stream_upsizer;

    localparam int DW = 32;
    localparam int F  = 4;
    localparam int SW = DW / 8;
    localparam int WW = F * DW;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            clear = 1'b0;
    logic            flush = 1'b0;
    logic            push_valid = 1'b0;
    logic            push_ready;
    logic [DW-1:0]   push_data = '0;
    logic [SW-1:0]   push_strb = '0;
    logic            pop_valid;
    logic            pop_ready = 1'b0;
    logic [WW-1:0]   pop_data;
    logic [F*SW-1:0] pop_strb;
    logic [$clog2(F):0] lanes;
    logic            empty;
`ifdef HWPE_STREAM_UPSIZER_STATS_EN
    logic [31:0]     words;
`endif

    hwpe_stream_upsizer #(.DATA_WIDTH(DW), .FACTOR(F)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (clear),
        .flush_i    (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .push_strb  (push_strb),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .pop_strb   (pop_strb),
        .lanes_o    (lanes),
        .empty_o    (empty)
`ifdef HWPE_STREAM_UPSIZER_STATS_EN
        ,
        .words_o    (words)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: beats gathered so far, and wide words owed downstream
    logic [DW-1:0]   lane_d[$];
    logic [SW-1:0]   lane_s[$];
    logic [WW-1:0]   exp_q[$];
    logic [F*SW-1:0] exp_strb_q[$];
    int              model_pops = 0;
    logic            held_valid = 1'b0;
    logic [WW-1:0]   held_data;
    logic [F*SW-1:0] held_strb;

    task automatic emit_word();
        logic [WW-1:0]   w;
        logic [F*SW-1:0] s;
        w = '0;
        s = '0;
        for (int i = 0; i < lane_d.size(); i++) begin
            w[i*DW +: DW] = lane_d[i];
            s[i*SW +: SW] = lane_s[i];
        end
        exp_q.push_back(w);
        exp_strb_q.push_back(s);
        lane_d.delete();
        lane_s.delete();
    endtask

    // scoreboard: observe the handshakes of the coming edge, mid-cycle
    always @(negedge clk) begin
        if (!rst_n || clear) begin
            lane_d.delete();
            lane_s.delete();
            exp_q.delete();
            exp_strb_q.delete();
            model_pops = 0;
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check("hold_valid", WW'(pop_valid), WW'(1));
                check("hold_data", pop_data, held_data);
                check("hold_strb", WW'(pop_strb), WW'(held_strb));
            end
            held_valid = pop_valid & ~pop_ready;
            held_data  = pop_data;
            held_strb  = pop_strb;
            if (pop_valid && pop_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pop", WW'(1), WW'(0));
                end else begin
                    check("pop_data", pop_data, exp_q.pop_front());
                    check("pop_strb", WW'(pop_strb), WW'(exp_strb_q.pop_front()));
                    model_pops++;
                end
            end
            if (push_valid && push_ready) begin
                lane_d.push_back(push_data);
                lane_s.push_back(push_strb);
                if (lane_d.size() == F) emit_word();
            end
            if (flush && lane_d.size() > 0) emit_word();
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input logic [SW-1:0] s);
        bit ok;
        ok = 1'b0;
        push_valid = 1'b1;
        push_data  = d;
        push_strb  = s;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (push_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("push_timeout", WW'(0), WW'(1));
        tick();
        push_valid = 1'b0;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    bit stalled;

    initial begin
        // reset state
        tick();
        tick();
        check("rst_pop_valid", WW'(pop_valid), WW'(0));
        check("rst_lanes", WW'(lanes), WW'(0));
        check("rst_empty", WW'(empty), WW'(1));
        rst_n = 1'b1;
        tick();

        // full word, pop always ready
        pop_ready = 1'b1;
        push_beat(32'h11, 4'hF);
        push_beat(32'h22, 4'hF);
        push_beat(32'h33, 4'hF);
        push_beat(32'h44, 4'hF);
        check("t1_valid", WW'(pop_valid), WW'(1));
        check("t1_data", pop_data, 128'h00000044_00000033_00000022_00000011);
        check("t1_strb", WW'(pop_strb), WW'(16'hFFFF));
        tick();
        check("t1_drained", WW'(pop_valid), WW'(0));

        // two beats then flush
        push_beat(32'hA, 4'hF);
        push_beat(32'hB, 4'hF);
        flush_pulse();
        check("t2_valid", WW'(pop_valid), WW'(1));
        check("t2_data", pop_data, 128'h0000000B_0000000A);
        check("t2_strb", WW'(pop_strb), WW'(16'h00FF));
        check("t2_lanes", WW'(lanes), WW'(0));
        tick();
        check("t2_empty", WW'(empty), WW'(1));

        // backpressure: second word blocks on its last beat
        pop_ready = 1'b0;
        for (int i = 0; i < 7; i++) push_beat(32'h100 + i, 4'hF);
        push_valid = 1'b1;
        push_data  = 32'h107;
        push_strb  = 4'hF;
        @(negedge clk);
        check("t3_push_blocked", WW'(push_ready), WW'(0));
        check("t3_held_word", pop_data, 128'h00000103_00000102_00000101_00000100);
        tick();
        pop_ready = 1'b1;
        tick();
        push_valid = 1'b0;
        check("t3_second_valid", WW'(pop_valid), WW'(1));
        check("t3_second_data", pop_data, 128'h00000107_00000106_00000105_00000104);
        tick();
        check("t3_drained", WW'(pop_valid), WW'(0));

        // flush with nothing stored, then flush alongside the third beat
        flush_pulse();
        check("t4_noop_valid", WW'(pop_valid), WW'(0));
        check("t4_noop_empty", WW'(empty), WW'(1));
        push_beat(32'h21, 4'hF);
        push_beat(32'h22, 4'hF);
        flush = 1'b1;
        push_beat(32'h23, 4'hF);
        flush = 1'b0;
        check("t4_valid", WW'(pop_valid), WW'(1));
        check("t4_data", pop_data, 128'h00000000_00000023_00000022_00000021);
        check("t4_strb", WW'(pop_strb), WW'(16'h0FFF));
        tick();

        // flush while the output slot is held
        pop_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_beat(32'h31 + i, 4'hF);
        flush_pulse();
        push_valid = 1'b1;
        push_data  = 32'h37;
        @(negedge clk);
        check("t5_push_frozen", WW'(push_ready), WW'(0));
        check("t5_not_empty", WW'(empty), WW'(0));
        check("t5_lanes", WW'(lanes), WW'(2));
        tick();
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        tick();
        check("t5_partial_valid", WW'(pop_valid), WW'(1));
        check("t5_partial_data", pop_data, 128'h00000036_00000035);
        check("t5_partial_strb", WW'(pop_strb), WW'(16'h00FF));
        tick();

        // clear mid-word
        push_beat(32'h41, 4'hF);
        push_beat(32'h42, 4'hF);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t6_clear_lanes", WW'(lanes), WW'(0));
        check("t6_clear_valid", WW'(pop_valid), WW'(0));
        check("t6_clear_empty", WW'(empty), WW'(1));
`ifdef HWPE_STREAM_UPSIZER_STATS_EN
        check("t6_clear_words", WW'(words), WW'(0));
`endif
        for (int i = 0; i < 4; i++) push_beat(32'h51 + i, 4'hF);
        check("t6_clean_data", pop_data, 128'h00000054_00000053_00000052_00000051);
        tick();

        // asynchronous reset mid-word
        push_beat(32'h61, 4'hF);
        push_beat(32'h62, 4'hF);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_lanes", WW'(lanes), WW'(0));
        check("t6_rst_valid", WW'(pop_valid), WW'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push_beat(32'h71 + i, 4'hF);
        check("t6_after_rst", pop_data, 128'h00000074_00000073_00000072_00000071);
        tick();

        // random traffic
        stalled = 1'b0;
        repeat (800) begin
            if (!stalled) begin
                push_valid = ($urandom_range(0, 3) != 0);
                push_data  = $urandom;
                push_strb  = SW'($urandom_range(0, (1 << SW) - 1));
            end
            pop_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            stalled = push_valid && !push_ready;
            tick();
        end
        push_valid = 1'b0;
        flush      = 1'b0;
        pop_ready  = 1'b1;
        tick();
        flush_pulse();
        repeat (6) tick();
        check("drain_exp_empty", WW'(exp_q.size()), WW'(0));
        check("drain_empty", WW'(empty), WW'(1));
`ifdef HWPE_STREAM_UPSIZER_STATS_EN
        check("words_count", WW'(words), WW'(model_pops));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
